// File: rtl/checkpoint_free_list.sv
// rtl/checkpoint_free_list.sv - multi-lane PRN free list with branch checkpoint save/restore/release
// Optional debug outputs are enabled by defining FREE_LIST_DEBUG_EN.
module checkpoint_free_list #(
    parameter int SIZE     = 64,
    parameter int WIDTH    = 2,
    parameter int RESERVED = 32,
    parameter int NUM_CKPT = 4,
    localparam int PRN_W   = $clog2(SIZE),
    localparam int PTR_W   = $clog2(SIZE),
    localparam int CNT_W   = $clog2(SIZE + 1),
    localparam int ID_W    = $clog2(NUM_CKPT)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             push_valid,
    input  logic [WIDTH-1:0][PRN_W-1:0]  push_prn,
    input  logic [WIDTH-1:0]             pop_en,
    output logic [WIDTH-1:0]             pop_valid,
    output logic [WIDTH-1:0][PRN_W-1:0]  pop_prn,
    input  logic                         ckpt_save,
    input  logic [ID_W-1:0]              ckpt_save_id,
    input  logic                         ckpt_restore,
    input  logic [ID_W-1:0]              ckpt_restore_id,
    input  logic                         ckpt_release,
    input  logic [ID_W-1:0]              ckpt_release_id,
    output logic [CNT_W-1:0]             free_count,
`ifdef FREE_LIST_DEBUG_EN
    output logic [SIZE-1:0][PRN_W-1:0]   dbg_entries,
    output logic [PTR_W-1:0]             dbg_head,
    output logic [PTR_W-1:0]             dbg_tail,
    output logic [NUM_CKPT-1:0]          dbg_ckpt_valid,
`endif
    output logic                         restore_err
);

    localparam int XW = CNT_W + 1;
    localparam logic [XW-1:0] ONE    = XW'(1);
    localparam logic [XW-1:0] SIZE_X = XW'(SIZE);

    logic [PRN_W-1:0]    entry   [SIZE];
    logic [PTR_W-1:0]    head, tail;
    logic [CNT_W-1:0]    count;
    logic [NUM_CKPT-1:0] ck_valid;
    logic [PTR_W-1:0]    ck_head  [NUM_CKPT];
    logic [CNT_W-1:0]    ck_base  [NUM_CKPT];
    logic [CNT_W-1:0]    ck_since [NUM_CKPT];

    logic             restore_hit;
    logic             save_eff;
    logic [XW-1:0]    pop_cnt;
    logic [XW-1:0]    push_cnt;
    logic [XW-1:0]    avail_base;
    logic [WIDTH-1:0] wr_en;
    logic [PTR_W-1:0] wr_ptr [WIDTH];
    logic [PTR_W-1:0] next_head;
    logic [PTR_W-1:0] next_tail;
    logic [CNT_W-1:0] next_count;

    always_comb begin
        restore_hit = ckpt_restore && ck_valid[ckpt_restore_id];
        save_eff    = ckpt_save && !restore_hit;

        // Grants only draw on registered occupancy; same-cycle pushes never feed pops.
        pop_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_valid[i] = 1'b0;
            pop_prn[i]   = '0;
            if (!restore_hit && pop_en[i] && ({1'b0, count} > pop_cnt)) begin
                pop_valid[i] = 1'b1;
                pop_prn[i]   = entry[head + PTR_W'(pop_cnt)];
                pop_cnt      = pop_cnt + ONE;
            end
        end

        // On a restore, capacity is judged against the checkpointed occupancy.
        if (restore_hit)
            avail_base = {1'b0, ck_base[ckpt_restore_id]} + {1'b0, ck_since[ckpt_restore_id]};
        else
            avail_base = {1'b0, count} - pop_cnt;

        push_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            wr_en[i]  = 1'b0;
            wr_ptr[i] = tail + PTR_W'(push_cnt);
            if (push_valid[i] && ((avail_base + push_cnt) < SIZE_X)) begin
                wr_en[i] = 1'b1;
                push_cnt = push_cnt + ONE;
            end
        end

        next_head  = restore_hit ? ck_head[ckpt_restore_id] : head + PTR_W'(pop_cnt);
        next_tail  = tail + PTR_W'(push_cnt);
        next_count = CNT_W'(avail_base + push_cnt);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SIZE; i++)
                entry[i] <= PRN_W'(i);
            head        <= PTR_W'(RESERVED);
            tail        <= '0;
            count       <= CNT_W'(SIZE - RESERVED);
            ck_valid    <= '0;
            restore_err <= 1'b0;
            for (int c = 0; c < NUM_CKPT; c++) begin
                ck_head[c]  <= '0;
                ck_base[c]  <= '0;
                ck_since[c] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++)
                if (wr_en[i])
                    entry[wr_ptr[i]] <= push_prn[i];
            head        <= next_head;
            tail        <= next_tail;
            count       <= next_count;
            restore_err <= ckpt_restore && !ck_valid[ckpt_restore_id];
            for (int c = 0; c < NUM_CKPT; c++) begin
                if (save_eff && (ckpt_save_id == ID_W'(c))) begin
                    ck_valid[c] <= 1'b1;
                    ck_head[c]  <= next_head;
                    ck_base[c]  <= next_count;
                    ck_since[c] <= '0;
                end else begin
                    if (ck_valid[c])
                        ck_since[c] <= ck_since[c] + CNT_W'(push_cnt);
                    if (ckpt_release && (ckpt_release_id == ID_W'(c)))
                        ck_valid[c] <= 1'b0;
                end
            end
        end
    end

    assign free_count = count;

`ifdef FREE_LIST_DEBUG_EN
    always_comb begin
        for (int i = 0; i < SIZE; i++)
            dbg_entries[i] = entry[i];
    end
    assign dbg_head       = head;
    assign dbg_tail       = tail;
    assign dbg_ckpt_valid = ck_valid;
`endif

endmodule

// File: tb/tb_checkpoint_free_list.sv
// tb/tb_checkpoint_free_list.sv - directed vector bench for checkpoint_free_list
module tb_checkpoint_free_list;

    logic             clock = 1'b0;
    logic             reset;
    logic [1:0]       push_valid;
    logic [1:0][5:0]  push_prn;
    logic [1:0]       pop_en;
    logic [1:0]       pop_valid;
    logic [1:0][5:0]  pop_prn;
    logic             ckpt_save;
    logic [1:0]       ckpt_save_id;
    logic             ckpt_restore;
    logic [1:0]       ckpt_restore_id;
    logic             ckpt_release;
    logic [1:0]       ckpt_release_id;
    logic [6:0]       free_count;
    logic             restore_err;

    int checks = 0;
    int errors = 0;

    checkpoint_free_list #(.SIZE(64), .WIDTH(2), .RESERVED(32), .NUM_CKPT(4)) dut (
        .clock(clock), .reset(reset),
        .push_valid(push_valid), .push_prn(push_prn),
        .pop_en(pop_en), .pop_valid(pop_valid), .pop_prn(pop_prn),
        .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
        .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id),
        .ckpt_release(ckpt_release), .ckpt_release_id(ckpt_release_id),
        .free_count(free_count), .restore_err(restore_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [1:0] pe, pv;
        logic [5:0] p0, p1;
        logic       sv; logic [1:0] svid;
        logic       rs; logic [1:0] rsid;
        logic       rl; logic [1:0] rlid;
        logic       cc;
        logic [1:0] epv;
        logic [5:0] ep0, ep1;
        logic [6:0] ecnt;
        logic       eerr;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(logic rst, logic [1:0] pe, logic [1:0] pv, logic [5:0] p0, logic [5:0] p1,
                                logic sv, logic [1:0] svid, logic rs, logic [1:0] rsid,
                                logic rl, logic [1:0] rlid, logic cc, logic [1:0] epv,
                                logic [5:0] ep0, logic [5:0] ep1, logic [6:0] ecnt, logic eerr);
        vec_t v;
        v.rst = rst; v.pe = pe; v.pv = pv; v.p0 = p0; v.p1 = p1;
        v.sv = sv; v.svid = svid; v.rs = rs; v.rsid = rsid; v.rl = rl; v.rlid = rlid;
        v.cc = cc; v.epv = epv; v.ep0 = ep0; v.ep1 = ep1; v.ecnt = ecnt; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; push_valid = '0; push_prn = '0; pop_en = '0;
        ckpt_save = 1'b0; ckpt_save_id = '0; ckpt_restore = 1'b0; ckpt_restore_id = '0;
        ckpt_release = 1'b0; ckpt_release_id = '0;
    endtask

    // Drive one cycle of pop/push at the falling edge, return sampled pop outputs.
    task automatic cyc(input logic [1:0] pe, input logic [1:0] pv, input logic [5:0] p0, input logic [5:0] p1,
                       output logic [1:0] gv, output logic [5:0] g0, output logic [5:0] g1);
        @(negedge clock);
        idle_inputs();
        pop_en = pe; push_valid = pv; push_prn[0] = p0; push_prn[1] = p1;
        #1;
        gv = pop_valid; g0 = pop_prn[0]; g1 = pop_prn[1];
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [1:0] gv;
        logic [5:0] g0, g1;
        int val;

        idle_inputs();
        //             rst pe    pv    p0 p1 sv svid rs rsid rl rlid cc epv   ep0 ep1 cnt err
        vecs[0]  = mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0,  0,  32, 0);
        vecs[1]  = mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 32, 33, 30, 0);
        vecs[2]  = mk(0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 1, 2'b00, 0,  0,  30, 0);
        vecs[3]  = mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 34, 35, 28, 0);
        vecs[4]  = mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 36, 37, 26, 0);
        vecs[5]  = mk(0, 2'b00, 2'b01, 5, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0,  0,  27, 0);
        vecs[6]  = mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 1, 2'b00, 0,  0,  31, 0);
        vecs[7]  = mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 34, 0,  30, 0);
        vecs[8]  = mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 1, 2, 0, 0, 1, 2'b11, 35, 36, 28, 1);
        vecs[9]  = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0,  0,  28, 0);
        vecs[10] = mk(0, 2'b00, 2'b01, 3, 0, 1, 0, 1, 1, 0, 0, 1, 2'b00, 0,  0,  32, 0);
        vecs[11] = mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2'b11, 34, 35, 30, 1);
        vecs[12] = mk(0, 2'b11, 2'b00, 0, 0, 1, 1, 1, 1, 0, 0, 1, 2'b00, 0,  0,  32, 0);
        vecs[13] = mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 34, 35, 30, 0);
        vecs[14] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2'b00, 0,  0,  30, 0);
        vecs[15] = mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 1, 2'b11, 36, 37, 28, 1);
        vecs[16] = mk(0, 2'b00, 2'b00, 0, 0, 1, 3, 0, 0, 0, 0, 1, 2'b00, 0,  0,  28, 0);
        vecs[17] = mk(1, 2'b11, 2'b00, 0, 0, 0, 0, 1, 3, 0, 0, 0, 2'b00, 0,  0,  32, 0);
        vecs[18] = mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 32, 33, 30, 0);
        vecs[19] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 3, 0, 0, 1, 2'b00, 0,  0,  30, 1);

        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            reset = vecs[k].rst; pop_en = vecs[k].pe; push_valid = vecs[k].pv;
            push_prn[0] = vecs[k].p0; push_prn[1] = vecs[k].p1;
            ckpt_save = vecs[k].sv; ckpt_save_id = vecs[k].svid;
            ckpt_restore = vecs[k].rs; ckpt_restore_id = vecs[k].rsid;
            ckpt_release = vecs[k].rl; ckpt_release_id = vecs[k].rlid;
            #1;
            if (vecs[k].cc) begin
                chk($sformatf("v%0d pop_valid", k), 32'(pop_valid), 32'(vecs[k].epv));
                chk($sformatf("v%0d pop_prn0", k), 32'(pop_prn[0]), 32'(vecs[k].ep0));
                chk($sformatf("v%0d pop_prn1", k), 32'(pop_prn[1]), 32'(vecs[k].ep1));
            end
            @(posedge clock);
            #1;
            chk($sformatf("v%0d free_count", k), 32'(free_count), 32'(vecs[k].ecnt));
            chk($sformatf("v%0d restore_err", k), 32'(restore_err), 32'(vecs[k].eerr));
        end

        // Wrap sequence: drain, refill positions 0..62 with value==position, then push across the wrap.
        @(negedge clock);
        idle_inputs();
        reset = 1'b1;
        @(posedge clock);
        #1;
        for (int k = 0; k < 16; k++) begin
            cyc(2'b11, 2'b00, 0, 0, gv, g0, g1);
            chk("drain prn0", 32'(g0), 32'(32 + 2 * k));
            chk("drain prn1", 32'(g1), 32'(33 + 2 * k));
        end
        chk("drained count", 32'(free_count), 0);
        cyc(2'b11, 2'b00, 0, 0, gv, g0, g1);
        chk("empty pop_valid", 32'(gv), 0);
        for (int k = 0; k < 31; k++)
            cyc(2'b00, 2'b11, 6'(2 * k), 6'(2 * k + 1), gv, g0, g1);
        cyc(2'b00, 2'b01, 62, 0, gv, g0, g1);
        chk("refill count", 32'(free_count), 63);
        cyc(2'b11, 2'b11, 7, 9, gv, g0, g1);
        chk("wrap pop prn0", 32'(g0), 0);
        chk("wrap pop prn1", 32'(g1), 1);
        chk("wrap count", 32'(free_count), 63);
        for (int k = 0; k < 31; k++) begin
            cyc(2'b11, 2'b00, 0, 0, gv, g0, g1);
            chk("wrap drain prn0", 32'(g0), 32'(2 + 2 * k));
            val = (3 + 2 * k == 63) ? 7 : 3 + 2 * k;
            chk("wrap drain prn1", 32'(g1), 32'(val));
        end
        cyc(2'b11, 2'b00, 0, 0, gv, g0, g1);
        chk("last pop_valid", 32'(gv), 32'(2'b01));
        chk("last pop_prn0", 32'(g0), 9);
        chk("last pop_prn1", 32'(g1), 0);
        chk("last free_count", 32'(free_count), 0);
        cyc(2'b00, 2'b01, 11, 0, gv, g0, g1);
        chk("tail push count", 32'(free_count), 1);
        cyc(2'b01, 2'b00, 0, 0, gv, g0, g1);
        chk("tail pop_valid", 32'(gv), 32'(2'b01));
        chk("tail pop_prn0", 32'(g0), 11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/checkpoint_free_list.md
CHECKPOINT_FREE_LIST -- requirements
Module: checkpoint_free_list

Interface
REQ-001 SHALL have parameter SIZE, default 64, number of physical register entries (power of two, >= 4).
REQ-002 SHALL have parameter WIDTH, default 2, number of push lanes and number of pop lanes.
REQ-003 SHALL have parameter RESERVED, default 32, count of PRNs allocated at reset (architectural map), 0 <= RESERVED < SIZE.
REQ-004 SHALL have parameter NUM_CKPT, default 4, number of branch checkpoint slots.
REQ-005 SHALL derive PRN_W = PTR_W = $clog2(SIZE), CNT_W = $clog2(SIZE+1), ID_W = $clog2(NUM_CKPT).
REQ-006 clock  in  1  single clock; all state updates on posedge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 push_valid  in  WIDTH  per-lane PRN return request.
REQ-009 push_prn  in  WIDTH x PRN_W  PRN returned per lane.
REQ-010 pop_en  in  WIDTH  per-lane allocation request.
REQ-011 pop_valid  out  WIDTH  lane granted a PRN this cycle.
REQ-012 pop_prn  out  WIDTH x PRN_W  granted PRN; 0 when lane not granted.
REQ-013 ckpt_save, ckpt_save_id  in  1, ID_W  take snapshot into slot.
REQ-014 ckpt_restore, ckpt_restore_id  in  1, ID_W  roll back to slot.
REQ-015 ckpt_release, ckpt_release_id  in  1, ID_W  invalidate slot (branch resolved correct).
REQ-016 free_count  out  CNT_W  registered occupancy.
REQ-017 restore_err  out  1  registered, high one cycle after restore of an invalid slot.

Function
REQ-018 Storage SHALL be a circular buffer of SIZE PRN entries with registered head, tail, count.
REQ-019 Pops SHALL be combinational from registered state: lanes in ascending order; lane i granted iff pop_en[i] and count > grants on lanes < i; granted lanes take consecutive entries from head.
REQ-020 Pushes SHALL be processed after pops in ascending lane order; lane accepted iff push_valid and (count - pops + accepted-so-far) < SIZE; accepted PRNs write at consecutive tail positions; rejected pushes dropped silently.
REQ-021 Pushes in a cycle SHALL NOT satisfy pops in the same cycle.
REQ-022 head and tail SHALL wrap modulo SIZE.
REQ-023 Each slot SHALL hold valid, head, base_count, push_since; on ckpt_save slot captures valid=1, head=next_head, base_count=next_count, push_since=0 (post-pop/post-push state of that cycle).
REQ-024 Every valid slot not being saved SHALL add the cycle's accepted push count to push_since.
REQ-025 On ckpt_restore of a valid slot: pops suppressed (pop_valid=0), head<=slot.head, count<=slot.base_count+slot.push_since+accepted pushes, push capacity judged against slot.base_count+slot.push_since, tail advances normally.
REQ-026 Restore SHALL leave the restored slot valid; ckpt_save in the same cycle SHALL be ignored.
REQ-027 Restore of an invalid slot SHALL be ignored (normal pop/push proceed) and set restore_err next cycle.
REQ-028 ckpt_release SHALL clear valid; save to same slot in the same cycle SHALL win.

Reset
REQ-029 On reset: entry[i]=i, head=RESERVED, tail=0, count=SIZE-RESERVED, all slots invalid, restore_err=0.
REQ-030 Reset SHALL override all inputs in the same cycle, including mid-restore; pop outputs reflect reset state next cycle.

Configuration
REQ-031 Macro FREE_LIST_DEBUG_EN defined: module SHALL add outputs dbg_entries (SIZE x PRN_W), dbg_head, dbg_tail (PTR_W), dbg_ckpt_valid (NUM_CKPT), all registered state.
REQ-032 Macro undefined: those ports SHALL be absent; function unchanged.

Verification (SIZE=64, WIDTH=2, RESERVED=32, NUM_CKPT=4)
REQ-033 Reset, pop_en=11 -> pop_prn={33,32} lanes1/0 valid; next free_count=30.
REQ-034 Drain to count=1, pop_en=11 -> lane0 valid, lane1 pop_valid=0, pop_prn[1]=0; next free_count=0.
REQ-035 head=34/count=30, save id1 -> pop 4 (34..37), push PRN 5 -> restore id1 -> free_count=31, next pop_prn[0]=34.
REQ-036 Push with tail=63, two lanes PRNs 7,9 -> entry[63]=7, entry[0]=9, tail=1.
REQ-037 Restore id2 never saved -> restore_err=1 next cycle, pops granted normally; save+restore same slot same cycle -> save ignored.
REQ-038 Reset asserted during restore cycle -> next cycle free_count=32, head=32, all slots invalid.
